// File: rtl/dmem_arbiter.sv
// Two-requester (core / host) arbiter in front of a single-port DMEM; 2-cycle read latency.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of core priority with starvation guard.
module dmem_arbiter #(
   parameter int DMEM_ADDR_WIDTH = 12,
   parameter int DMEM_WORD_WIDTH = 16,
   parameter int HOST_MAX_WAIT   = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       core_req_valid,
   output logic                       core_req_ready,
   input  logic                       core_req_we,
   input  logic [DMEM_ADDR_WIDTH-1:0] core_req_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] core_req_wdata,
   output logic                       core_rsp_valid,
   output logic [DMEM_WORD_WIDTH-1:0] core_rsp_rdata,
   input  logic                       host_req_valid,
   output logic                       host_req_ready,
   input  logic                       host_req_we,
   input  logic [DMEM_ADDR_WIDTH-1:0] host_req_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] host_req_wdata,
   output logic                       host_rsp_valid,
   output logic [DMEM_WORD_WIDTH-1:0] host_rsp_rdata,
   output logic                       mem_en,
   output logic                       mem_we,
   output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DMEM_WORD_WIDTH-1:0] mem_wdata,
   input  logic [DMEM_WORD_WIDTH-1:0] mem_rdata
);

   // Handshake: a request is accepted in the cycle where valid & ready are both high;
   // ready is combinational, never high without valid, and low while reset is asserted.

   logic w_host_pri;
   logic w_core_gnt;
   logic w_host_gnt;
   logic w_accept;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic r_rr_host;

   assign w_host_pri = r_rr_host;

   // Pointer only moves on contested cycles; it then favours the loser next time.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rr_host <= 1'b0;
      end else if (core_req_valid && host_req_valid) begin
         r_rr_host <= w_core_gnt;
      end
   end
`else
   localparam int CNT_W = $clog2(HOST_MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_MAX_WAIT);

   logic [CNT_W-1:0] r_starve_cnt;

   assign w_host_pri = (r_starve_cnt == CNT_MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_starve_cnt <= '0;
      end else if (!host_req_valid || w_host_gnt) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != CNT_MAX) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end
`endif

   assign w_host_gnt = reset & host_req_valid & (~core_req_valid | w_host_pri);
   assign w_core_gnt = reset & core_req_valid & ~(host_req_valid & w_host_pri);
   assign w_accept   = w_core_gnt | w_host_gnt;

   assign core_req_ready = w_core_gnt;
   assign host_req_ready = w_host_gnt;

   // Command stage: registered DMEM command plus owner tag.
   logic r_mem_en;
   logic r_mem_we;
   logic [DMEM_ADDR_WIDTH-1:0] r_mem_addr;
   logic [DMEM_WORD_WIDTH-1:0] r_mem_wdata;
   logic r_c_host;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_c_host    <= 1'b0;
      end else begin
         r_mem_en <= w_accept;
         r_mem_we <= w_host_gnt ? host_req_we : (w_core_gnt & core_req_we);
         r_c_host <= w_host_gnt;
         if (w_accept) begin
            r_mem_addr  <= w_host_gnt ? host_req_addr  : core_req_addr;
            r_mem_wdata <= w_host_gnt ? host_req_wdata : core_req_wdata;
         end
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   // Response stage: valid is registered from the read tag; data passes straight from DMEM
   // while valid and is held afterwards so each owner's rdata keeps its last value.
   logic r_core_rsp_valid;
   logic r_host_rsp_valid;
   logic [DMEM_WORD_WIDTH-1:0] r_core_rdata;
   logic [DMEM_WORD_WIDTH-1:0] r_host_rdata;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_core_rsp_valid <= 1'b0;
         r_host_rsp_valid <= 1'b0;
         r_core_rdata     <= '0;
         r_host_rdata     <= '0;
      end else begin
         r_core_rsp_valid <= r_mem_en & ~r_mem_we & ~r_c_host;
         r_host_rsp_valid <= r_mem_en & ~r_mem_we & r_c_host;
         if (r_core_rsp_valid) begin
            r_core_rdata <= mem_rdata;
         end
         if (r_host_rsp_valid) begin
            r_host_rdata <= mem_rdata;
         end
      end
   end

   assign core_rsp_valid = r_core_rsp_valid;
   assign host_rsp_valid = r_host_rsp_valid;
   assign core_rsp_rdata = r_core_rsp_valid ? mem_rdata : r_core_rdata;
   assign host_rsp_rdata = r_host_rsp_valid ? mem_rdata : r_host_rdata;

endmodule
